debug_mem_dump_reader: RTL and testbench
========================================

# debug_mem_dump_reader

Debug-unit block that reads back the data memory through the memory stage's debug address port and serialises every dirty word onto the byte-wide UART transmit interface. It walks word addresses, drives the memory-stage address mux select and debug address, and samples the conditioned read data and dirty bit. Each dirty word goes out as a 6-byte frame; one end marker closes the dump. It is the reading counterpart of the memory stage's debug read port.

## Interface
Parameters:
- CANT_BITS_ADDR, 12, byte address width; the two LSBs are always 0 on output.
- CANT_BITS_REGISTROS, 32, data word width; fixed at 32 for framing.
- RAM_DEPTH, 1024, number of 32-bit words scanned.

Ports:
- i_clock  in  1  single clock; all logic on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a dump; ignored while o_busy=1.
- o_control_address_mem  out  1  memory address mux select; 1 = debug address.
- o_address_debug_unit  out  CANT_BITS_ADDR  byte address = word_index<<2.
- i_dato_mem  in  CANT_BITS_REGISTROS  read data from the memory stage.
- i_bit_sucio  in  1  dirty bit of the addressed word.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- i_tx_done  in  1  one-cycle pulse: the current byte has been sent.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, SET_ADDR, WAIT_MEM, CAPTURE, SEND, WAIT_TX, NEXT, SEND_END, WAIT_END, DONE.
- IDLE: i_start -> SET_ADDR. The word index is cleared and o_busy and o_control_address_mem are set.
- SET_ADDR: o_address_debug_unit <= index<<2. Then -> WAIT_MEM -> CAPTURE.
- CAPTURE: latch i_dato_mem and i_bit_sucio. If the word is dirty -> SEND with byte_cnt=0; otherwise -> NEXT.
- Frame bytes, in order:
  - addr[15:8] (zero-extended byte address)
  - addr[7:0]
  - data[31:24], data[23:16], data[15:8], data[7:0]
- SEND: drive o_tx_data and pulse o_tx_start for one cycle, then -> WAIT_TX.
- WAIT_TX: on i_tx_done, byte_cnt++. If byte_cnt was 5 -> NEXT; otherwise -> SEND.
- NEXT: if index == RAM_DEPTH-1 -> SEND_END; otherwise index++ and -> SET_ADDR.
- SEND_END: o_tx_data=0xFF and pulse o_tx_start, then -> WAIT_END. 0xFF cannot be an address high byte when CANT_BITS_ADDR ≤ 15.
- WAIT_END: on i_tx_done -> DONE.
- DONE: pulse o_done, clear o_busy and o_control_address_mem, then -> IDLE.
- o_tx_data is held stable from SEND until i_tx_done.
- i_tx_done outside WAIT_TX/WAIT_END is ignored.
- i_start outside IDLE is ignored.
- Index counter width: clogb2(RAM_DEPTH-1). No wrap occurs, because NEXT terminates at RAM_DEPTH-1.

## Timing
- Reset values: o_control_address_mem=0, o_address_debug_unit=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0, state IDLE.
- Reset mid-dump aborts immediately. The mux returns to the pipeline (select=0) asynchronously, and no further bytes are transmitted.
- o_busy and o_control_address_mem rise on the first edge after i_start.
- The address is stable one full cycle before CAPTURE, matching the one-cycle LOW_LATENCY memory read.
- Clean word: 4 cycles (SET_ADDR, WAIT_MEM, CAPTURE, NEXT).
- Dirty word: 4 + 6×(1 + tx latency) cycles.
- o_done rises one cycle after the end marker's i_tx_done and lasts exactly one cycle.
- i_tx_done arriving in the same cycle as o_tx_start is not accepted; the earliest acceptance is the following cycle.

## Configuration
- DEBUG_MEM_DUMP_ALL_EN defined: every word is framed and transmitted regardless of i_bit_sucio, giving RAM_DEPTH×6+1 bytes.
- DEBUG_MEM_DUMP_ALL_EN undefined: only words with i_bit_sucio=1 are transmitted; CAPTURE skips clean words.

## Test plan
- Macro off, no dirty words, i_tx_done returned 2 cycles after each o_tx_start -> exactly one byte (0xFF). o_done arrives ≈4096 cycles after start, and select=1 throughout o_busy.
- Macro off, word 5 dirty = 0xDEADBEEF -> bytes 0x00, 0x14, 0xDE, 0xAD, 0xBE, 0xEF, 0xFF.
- Macro off, word 1023 dirty = 0x00000001 -> bytes 0x0F, 0xFC, 0x00, 0x00, 0x00, 0x01, 0xFF; no address beyond 0xFFC is driven.
- i_tx_done held off 50 cycles -> o_tx_data is unchanged and no second o_tx_start is issued. A second i_start during the dump is ignored, and a stray i_tx_done in SET_ADDR is ignored.
- Assert i_reset during the third data byte -> all outputs return to reset values within the same cycle, no further o_tx_start, and a subsequent i_start restarts at address 0.
- Macro on, all memory clean -> 6145 bytes, with the address field incrementing by 4 each frame.

Source files
------------

// File: rtl/debug_mem_dump_reader.sv
// -----------------------------------------------------------------------------
// debug_mem_dump_reader
//
// Walks every word of the data memory through the memory stage's debug read
// port and serialises each dirty word onto a byte-wide UART transmit
// interface. Each transmitted word is a 6-byte frame:
//   addr[15:8], addr[7:0], data[31:24], data[23:16], data[15:8], data[7:0]
// where addr is the zero-extended byte address. A single 0xFF byte closes the
// dump. 0xFF can never be an address high byte while CANT_BITS_ADDR <= 15.
//
// Build option:
//   DEBUG_MEM_DUMP_ALL_EN  defined   -> every word is framed, dirty or not.
//                          undefined -> only words with i_bit_sucio=1.
//
// Ports:
//   i_clock                single clock, posedge
//   i_reset                asynchronous active-high reset
//   i_start                one-cycle pulse, starts a dump (ignored while busy)
//   o_control_address_mem  memory address mux select, 1 = debug address
//   o_address_debug_unit   byte address driven to memory (word_index << 2)
//   i_dato_mem             read data, valid one cycle after the address
//   i_bit_sucio            dirty bit of the addressed word, same timing
//   o_tx_data              byte to transmit, stable until i_tx_done
//   o_tx_start             one-cycle transmit request
//   i_tx_done              one-cycle pulse: current byte has been sent
//   o_busy                 high from the accepted start through the done cycle
//   o_done                 one-cycle pulse when the dump completes
// -----------------------------------------------------------------------------
module debug_mem_dump_reader #(
  parameter int CANT_BITS_ADDR      = 12,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int RAM_DEPTH           = 1024
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  output logic                           o_control_address_mem,
  output logic [CANT_BITS_ADDR-1:0]      o_address_debug_unit,
  input  logic [CANT_BITS_REGISTROS-1:0] i_dato_mem,
  input  logic                           i_bit_sucio,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_start,
  input  logic                           i_tx_done,
  output logic                           o_busy,
  output logic                           o_done
);

  // Enough bits to hold RAM_DEPTH-1; the scan stops there, so no wrap.
  localparam int                IDX_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(RAM_DEPTH - 1);
  localparam logic [2:0]        LAST_BYTE  = 3'd5;
  localparam logic [7:0]        END_MARKER = 8'hFF;

  typedef enum logic [3:0] {
    IDLE, SET_ADDR, WAIT_MEM, CAPTURE, SEND, WAIT_TX, NEXT, SEND_END, WAIT_END, DONE
  } state_t;

  state_t                         state, state_next;
  logic [IDX_W-1:0]               index;
  logic [2:0]                     byte_cnt;
  logic [CANT_BITS_REGISTROS-1:0] data_q;
  logic [15:0]                    frame_addr;
  logic                           take_word;

  // Frame address is the byte address zero-extended to 16 bits.
  assign frame_addr = 16'(o_address_debug_unit);

`ifdef DEBUG_MEM_DUMP_ALL_EN
  // Every word is framed; the dirty bit is irrelevant in this build.
  assign take_word = 1'b1 | i_bit_sucio;
`else
  assign take_word = i_bit_sucio;
`endif

  function automatic logic [7:0] frame_byte(input logic [2:0]  sel,
                                            input logic [15:0] addr,
                                            input logic [31:0] data);
    case (sel)
      3'd0:    frame_byte = addr[15:8];
      3'd1:    frame_byte = addr[7:0];
      3'd2:    frame_byte = data[31:24];
      3'd3:    frame_byte = data[23:16];
      3'd4:    frame_byte = data[15:8];
      default: frame_byte = data[7:0];
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: the default assignment first guarantees state_next is written on
  // every path, so no latch is inferred for the cases that simply hold.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (i_start) state_next = SET_ADDR;
      SET_ADDR: state_next = WAIT_MEM;
      WAIT_MEM: state_next = CAPTURE;
      CAPTURE:  state_next = take_word ? SEND : NEXT;
      SEND:     state_next = WAIT_TX;
      // i_tx_done is only looked at here and in WAIT_END, so a done pulse
      // coinciding with o_tx_start (state SEND) is never accepted.
      WAIT_TX:  if (i_tx_done) state_next = (byte_cnt == LAST_BYTE) ? NEXT : SEND;
      NEXT:     state_next = (index == LAST_IDX) ? SEND_END : SET_ADDR;
      SEND_END: state_next = WAIT_END;
      WAIT_END: if (i_tx_done) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state
  // they belong to and all drop to zero together on an asynchronous reset.
  // NOTE: every register here is a control/datapath flop, so each one gets
  // an explicit reset value; there is no storage array to leave unreset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_control_address_mem <= 1'b0;
      o_address_debug_unit  <= '0;
      o_tx_data             <= '0;
      o_tx_start            <= 1'b0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      index                 <= '0;
      byte_cnt              <= '0;
      data_q                <= '0;
    end else begin
      o_tx_start            <= (state_next == SEND) || (state_next == SEND_END);
      o_done                <= (state_next == DONE);
      o_busy                <= (state_next != IDLE);
      o_control_address_mem <= (state_next != IDLE);

      case (state)
        IDLE:
          if (i_start) index <= '0;
        SET_ADDR:
          o_address_debug_unit <= CANT_BITS_ADDR'({index, 2'b00});
        CAPTURE:
          if (take_word) begin
            data_q    <= i_dato_mem;
            byte_cnt  <= '0;
            o_tx_data <= frame_byte(3'd0, frame_addr, i_dato_mem);
          end
        WAIT_TX:
          // Next byte is loaded only once the current one is acknowledged,
          // which keeps o_tx_data stable for the whole transmission.
          if (i_tx_done && (byte_cnt != LAST_BYTE)) begin
            byte_cnt  <= byte_cnt + 3'd1;
            o_tx_data <= frame_byte(byte_cnt + 3'd1, frame_addr, data_q);
          end
        NEXT:
          if (index != LAST_IDX) index <= index + 1'b1;
          else                   o_tx_data <= END_MARKER;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_dump_reader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for debug_mem_dump_reader. A registered-read memory
// model and a UART responder surround the DUT; the expected byte stream and
// dump duration are computed from the memory contents with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_debug_mem_dump_reader;

  localparam int DEPTH = 1024;
`ifdef DEBUG_MEM_DUMP_ALL_EN
  localparam bit ALL_EN = 1'b1;
  localparam int LAT    = 1;
  localparam int N_RAND = 0;
`else
  localparam bit ALL_EN = 1'b0;
  localparam int LAT    = 2;
  localparam int N_RAND = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel;
  logic [11:0] addr;
  logic [31:0] dato = '0;
  logic        sucio = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  debug_mem_dump_reader #(
    .CANT_BITS_ADDR(12), .CANT_BITS_REGISTROS(32), .RAM_DEPTH(DEPTH)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_control_address_mem(sel), .o_address_debug_unit(addr),
    .i_dato_mem(dato), .i_bit_sucio(sucio),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  // Memory model: one-cycle registered read.
  logic [31:0] mem   [DEPTH];
  bit          dirty [DEPTH];
  always @(posedge clk) begin
    dato  <= mem[addr[11:2]];
    sucio <= dirty[addr[11:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // UART responder: records each requested byte, answers after lat cycles.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] held;
  bit         pending  = 0;
  bit         stray_en = 0;
  bit         early_en = 0;
  int         lat      = 2;
  int         cnt      = 0;
  int         proto_err = 0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      pending = 0;
    end else if (tx_start) begin
      if (pending) proto_err++;
      got_q.push_back(tx_data);
      held    = tx_data;
      pending = 1;
      cnt     = lat;
      if (early_en) tx_done = 1'b1;  // must be ignored by the DUT
    end else if (pending) begin
      if (tx_data !== held) proto_err++;
      if (cnt <= 1) begin
        tx_done = 1'b1;
        pending = 0;
      end else begin
        cnt--;
      end
    end else if (stray_en && $urandom_range(0, 5) == 0) begin
      tx_done = 1'b1;
    end
  end

  // Protocol monitor.
  longint cyc = 0;
  int     sel_err = 0, addr_err = 0, done_hi = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy !== sel) sel_err++;
      if (addr[1:0] !== 2'b00) addr_err++;
      if (done) done_hi++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = '0;
      dirty[i] = 1'b0;
    end
  endtask

  task automatic build_expected(output int k);
    logic [15:0] a;
    exp_q.delete();
    k = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ALL_EN || dirty[i]) begin
        a = 16'(i * 4);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(mem[i][31:24]);
        exp_q.push_back(mem[i][23:16]);
        exp_q.push_back(mem[i][15:8]);
        exp_q.push_back(mem[i][7:0]);
        k++;
      end
    end
    exp_q.push_back(8'hFF);
  endtask

  task automatic run_dump(input string tag, input int latency, input bit timed);
    int     k, nbad, n;
    longint s_cyc, d_cyc;
    bit     seen;
    build_expected(k);
    got_q.delete();
    sel_err = 0; addr_err = 0; done_hi = 0; proto_err = 0;
    lat = latency;
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_sel_rise"}, sel, 1);
    seen  = 0;
    d_cyc = 0;
    for (int i = 0; i < 200000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1;
        d_cyc = cyc;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    // Start cycle, then per word SET_ADDR/WAIT_MEM/CAPTURE/NEXT, six bytes of
    // (request + latency) per framed word, the end marker, then DONE.
    if (timed && seen)
      check({tag, "_duration"}, d_cyc - s_cyc, 1 + 4 * DEPTH + k * 6 * (1 + latency) + (1 + latency));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_sel_fall"}, sel, 0);
    check({tag, "_byte_count"}, got_q.size(), exp_q.size());
    nbad = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) nbad++;
    check({tag, "_stream_bad_bytes"}, nbad, 0);
    check({tag, "_sel_vs_busy_err"}, sel_err, 0);
    check({tag, "_addr_align_err"}, addr_err, 0);
    check({tag, "_tx_protocol_err"}, proto_err, 0);
    check({tag, "_done_pulses"}, done_hi, 1);
  endtask

  task automatic check_literal(input string tag, input logic [7:0] lit [7]);
    check({tag, "_lit_size"}, got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++)
      check($sformatf("%s_lit_byte%0d", tag, i), got_q[i], lit[i]);
  endtask

  initial begin
    logic [7:0] lit [7];
    logic [7:0] first_byte;
    int         nbad;
    logic [15:0] fa;

    clear_mem();
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_sel",     sel, 0);
    check("rst_addr",    addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: nothing dirty.
    run_dump("clean", LAT, 1'b1);
`ifdef DEBUG_MEM_DUMP_ALL_EN
    check("clean_all_bytes", got_q.size(), DEPTH * 6 + 1);
    nbad = 0;
    for (int f = 0; f < DEPTH && f * 6 + 1 < got_q.size(); f++) begin
      fa = {got_q[f*6], got_q[f*6+1]};
      if (fa != 16'(f * 4)) nbad++;
    end
    check("clean_addr_increment_bad", nbad, 0);
`else
    check("clean_only_marker", got_q.size(), 1);
    if (got_q.size() > 0) check("clean_marker", got_q[0], 8'hFF);
`endif

    // 2: word 5 dirty.
    clear_mem();
    mem[5] = 32'hDEADBEEF; dirty[5] = 1'b1;
    run_dump("word5", LAT, 1'b1);
`ifndef DEBUG_MEM_DUMP_ALL_EN
    lit = '{8'h00, 8'h14, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
    check_literal("word5", lit);
`endif

    // 3: last word dirty.
    clear_mem();
    mem[DEPTH-1] = 32'h00000001; dirty[DEPTH-1] = 1'b1;
    run_dump("word1023", LAT, 1'b1);
`ifndef DEBUG_MEM_DUMP_ALL_EN
    lit = '{8'h0F, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    check_literal("word1023", lit);
`endif

    // 4: long transmit latency, stray done pulses, second start while busy.
    clear_mem();
    mem[2] = 32'h12345678; dirty[2] = 1'b1;
    mem[9] = 32'hA5C3F00F; dirty[9] = 1'b1;
    stray_en = 1;
    fork
      run_dump("holdoff", 50, 1'b0);
      begin
        @(negedge clk);
        for (int i = 0; i < 2000 && got_q.size() == 0; i++) @(negedge clk);
        check("holdoff_first_seen", got_q.size(), 1);
        first_byte = tx_data;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("holdoff_tx_data_held", tx_data, first_byte);
        check("holdoff_no_second_start", got_q.size(), 1);
        lat = 1;
      end
    join
    stray_en = 0;

    // 5: reset during the third data byte of the second frame.
    clear_mem();
    mem[3] = 32'h01020304; dirty[3] = 1'b1;
    mem[7] = 32'hCAFEF00D; dirty[7] = 1'b1;
    got_q.delete();
    lat = 4;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5000 && got_q.size() < 11; i++) @(negedge clk);
    check("abort_reached_byte", got_q.size(), 11);
    check("abort_byte_value", got_q[got_q.size()-1], 8'hF0);
    #2 rst = 1'b1;
    #1;
    check("abort_sel",      sel, 0);
    check("abort_addr",     addr, 0);
    check("abort_tx_data",  tx_data, 0);
    check("abort_tx_start", tx_start, 0);
    check("abort_busy",     busy, 0);
    check("abort_done",     done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_more_bytes", got_q.size(), 11);
    check("abort_idle_busy", busy, 0);
    run_dump("restart", 4, 1'b1);

    // Randomised contents, latency and early done pulses.
    for (int r = 0; r < N_RAND; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]   = $urandom;
        dirty[i] = ($urandom_range(0, 63) == 0);
      end
      early_en = $urandom_range(0, 1);
      run_dump($sformatf("rand%0d", r), $urandom_range(1, 4), 1'b1);
      early_en = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
